// File: rtl/eth_pkg.sv
// Types and constants shared by the Ethernet TX/RX frame plumbing.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        STREAM,
        DRAIN,
        GAP
    } tx_arb_state_t;

    localparam int ETH_MAX_FRAME = 1514;
    localparam int ETH_IFG_BYTES = 12;

    typedef logic [7:0] eth_byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first requester after the one-hot 'last' position.
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] last,
    output logic [N_SRC-1:0] gnt,
    output logic             any
);

    int last_idx;
    int best_idx;
    int best_pri;
    int pri;

    always_comb begin
        last_idx = N_SRC - 1;
        for (int i = 0; i < N_SRC; i++) begin
            if (last[i]) last_idx = i;
        end

        // Priority 0 is the slot right after 'last', rising as we wrap around.
        best_idx = 0;
        best_pri = N_SRC;
        for (int i = 0; i < N_SRC; i++) begin
            pri = (i + 2 * N_SRC - last_idx - 1) % N_SRC;
            if (req[i] && (pri < best_pri)) begin
                best_pri = pri;
                best_idx = i;
            end
        end

        any = |req;
        gnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            gnt[i] = req[i] && (i == best_idx);
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin whole-frame arbiter sharing the MAC TX byte port among N_SRC protocol sources,
// with inter-frame gap enforcement and over-long frame truncation.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int IFG_CYCLES      = ETH_IFG_BYTES,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
    input  logic               CLK_TX,
    input  logic               ARESET,
    input  logic [N_SRC-1:0]   SRC_DATA_VALID,
    input  logic [8*N_SRC-1:0] SRC_DATA,
    output logic [N_SRC-1:0]   SRC_DATA_ACK,
    output logic               DATA_VALID_TX,
    output logic [7:0]         DATA_TX,
    input  logic               DATA_ACK_TX,
    output logic [N_SRC-1:0]   GRANT,
    output logic               ERR_OVERLONG
);

    localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [BW-1:0]    BYTE_MAX  = BW'(MAX_FRAME_BYTES);
    localparam logic [GW-1:0]    GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [N_SRC-1:0] RR_INIT   = {1'b1, {(N_SRC-1){1'b0}}};
    localparam tx_arb_state_t    END_STATE = (IFG_CYCLES > 0) ? GAP : IDLE;

    tx_arb_state_t    state;
    tx_arb_state_t    state_n;
    logic [N_SRC-1:0] grant_n;
    logic [N_SRC-1:0] rr_last;
    logic [N_SRC-1:0] rr_last_n;
    logic [N_SRC-1:0] pick_gnt;
    logic             pick_any;
    logic [BW-1:0]    byte_cnt;
    logic [BW-1:0]    byte_cnt_n;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_cnt_n;
    logic             sel_valid;
    eth_byte_t        sel_data;

    rr_pick #(
        .N_SRC(N_SRC)
    ) u_rr_pick (
        .req (SRC_DATA_VALID),
        .last(rr_last),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Granted source's stream, selected straight off the registered grant (no added latency).
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (GRANT[i]) sel_data = SRC_DATA[8*i +: 8];
        end
        sel_valid = |(SRC_DATA_VALID & GRANT);
    end

    always_comb begin
        state_n       = state;
        grant_n       = GRANT;
        rr_last_n     = rr_last;
        byte_cnt_n    = byte_cnt;
        gap_cnt_n     = gap_cnt;
        DATA_VALID_TX = 1'b0;
        SRC_DATA_ACK  = '0;
        ERR_OVERLONG  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n   = pick_gnt;
                    rr_last_n = pick_gnt;
                    state_n   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                DATA_VALID_TX = sel_valid;
                if (!sel_valid) begin
                    grant_n = '0;
                    state_n = IDLE;
                end else if (DATA_ACK_TX) begin
                    SRC_DATA_ACK = GRANT;
                    byte_cnt_n   = BW'(1);
                    state_n      = STREAM;
                end
            end
            STREAM: begin
                if (!sel_valid) begin
                    grant_n   = '0;
                    gap_cnt_n = '0;
                    state_n   = END_STATE;
                end else if (byte_cnt < BYTE_MAX) begin
                    DATA_VALID_TX = 1'b1;
                    byte_cnt_n    = byte_cnt + 1'b1;
                end else begin
                    ERR_OVERLONG = 1'b1;
                    state_n      = DRAIN;
                end
            end
            // Grant stays with the truncated source until it ends its frame on its own.
            DRAIN: begin
                if (!sel_valid) begin
                    grant_n   = '0;
                    gap_cnt_n = '0;
                    state_n   = END_STATE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase

        DATA_TX = DATA_VALID_TX ? sel_data : 8'h00;
    end

    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) begin
            state    <= IDLE;
            GRANT    <= '0;
            rr_last  <= RR_INIT;
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            GRANT    <= grant_n;
            rr_last  <= rr_last_n;
            byte_cnt <= byte_cnt_n;
            gap_cnt  <= gap_cnt_n;
        end
    end

endmodule
